axi_stream_remove_header: RTL
=============================

# axi_stream_remove_header

Downstream counterpart of `axi_stream_insert_header`: strips a per-frame, programmable number of leading bytes (0..DATA_BYTE_WD) from each AXI-Stream frame and re-packs the remaining bytes MSB-first, so every non-final output beat is full. It sits on the consumer side of the header-insert stage and restores the original payload framing, including the last-beat `keep` value. Output is registered, with full-throughput valid/ready handshaking on both sides.

## Interface
- `DATA_WD`, 32, data bus width in bits.
- `DATA_BYTE_WD`, DATA_WD/8, bytes per beat.
- `BYTE_CNT_WD`, $clog2(DATA_BYTE_WD), byte-index width.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `valid_in`  in  1  input beat valid.
- `data_in`  in  DATA_WD  input data; byte 0 = `data_in[DATA_WD-1 -: 8]` (first on the wire).
- `keep_in`  in  DATA_BYTE_WD  byte enables; all-ones except on the last beat, where they are leading-ones (MSB contiguous, at least one bit set).
- `last_in`  in  1  final beat of frame.
- `byte_remove_cnt`  in  BYTE_CNT_WD+1  bytes to strip; sampled with the first beat of each frame.
- `ready_in`  out  1  input accepted when `valid_in && ready_in`.
- `valid_out`  out  1  output beat valid.
- `data_out`  out  DATA_WD  output data, MSB-first; bytes with `keep_out` low are driven 0.
- `keep_out`  out  DATA_BYTE_WD  all-ones except the last beat (leading-ones).
- `last_out`  out  1  final beat of output frame.
- `ready_out`  in  1  downstream ready.

## Operation
- **States:**
  - FIRST: next accepted beat is the frame head.
  - STREAM: mid-frame.
  - FLUSH: last input beat consumed, residue still pending.
- **Removal count R:**
  - R = `byte_remove_cnt`, latched on the FIRST-state handshake.
  - Values > DATA_BYTE_WD are clamped to DATA_BYTE_WD.
  - R applies only to that frame.
- **Residue buffer:** holds up to DATA_BYTE_WD-1 bytes plus a byte count `res_cnt`.
- **Head beat:**
  - Discard its first min(R, n) valid bytes, where n is the popcount of `keep_in`.
  - Remaining bytes go to the residue.
- **Each subsequent beat:**
  - Append the beat's bytes to the residue.
  - If the total is ≥ DATA_BYTE_WD, emit the top DATA_BYTE_WD bytes as a full beat and keep the remainder.
- **On the `last_in` beat:**
  - If the emitted full beat exhausts all bytes, it carries `last_out`.
  - If bytes remain with no full beat, emit them as one partial beat with `last_out` and leading-ones `keep_out`.
  - If a full beat is emitted and bytes remain, go to FLUSH; the residue follows as the next output beat with `last_out`.
- **Frame fully stripped:** if total frame bytes ≤ R, no output beat is produced (the frame is dropped) and the block returns to FIRST.
- **R = 0:** pass-through with a one-beat registered delay; `keep`, `last` and data are unchanged.
- Steady-state `res_cnt` = (DATA_BYTE_WD − R) mod DATA_BYTE_WD within a frame.

## Timing
- **Reset:** while `rst` is high at a clock edge:
  - `valid_out`=0, `data_out`=0, `keep_out`=0, `last_out`=0.
  - State = FIRST, residue cleared.
  - `ready_in`=0 while `rst` is high.
- **Reset mid-frame:** any partial frame is discarded. After reset deasserts, the next beat is treated as a frame head.
- **Ready:**
  - `ready_in` = !rst && state≠FLUSH && (!valid_out || ready_out).
  - The output register loads in the same cycle it is freed, giving full throughput of 1 beat/cycle.
- **Latency:**
  - R=0: the output beat is valid the cycle after input acceptance.
  - R>0: the first output beat follows acceptance of the input beat that completes it (the 2nd beat, or the last beat for a short frame).
- **FLUSH:**
  - Lasts until the residue beat loads into the output register, minimum 1 cycle.
  - `ready_in`=0 during FLUSH.
  - Exits to FIRST.
- **Back-to-back frames:** the head of frame N+1 may be accepted the cycle after FLUSH exits. With no FLUSH, it may be accepted the cycle after `last_in`.
- **Output stability:** while `valid_out && !ready_out`, all outputs hold stable.
- **Input stability:** `valid_in` must not depend on `ready_in`; a source may present data first.

## Test plan
1. **R=1, two-beat frame.** R=1, beats 0xAABBCCDD (1111), then 0x11223344 (1111, last), `ready_out`=1 → output 0xBBCCDD11 keep 1111, then 0x22334400 keep 1110 last. Checks: FLUSH entered, `ready_in` low 1 cycle.
2. **R=0 pass-through.** R=0, single beat 0x0102FFFF keep 1100 last → output 0x01020000 keep 1100 last, one cycle later.
3. **R=2, partial last beat.** R=2, beats 0x11223344 (1111), then 0x55667788 (1000, last) → single output 0x33445500 keep 1110 last, with no FLUSH.
4. **Dropped frame, then clamped R.**
   - R=4, single beat 0xAABBCCDD (1111, last) → no output beat, `ready_in` stays 1.
   - Next frame with R=7 (clamped to 4), two full beats, last → one output beat equal to the second input beat, keep 1111, last.
5. **Backpressure.** Random 20% `ready_out`, three back-to-back frames with random R and random last-beat keep; a byte-queue scoreboard checks every output byte, keep and last. `valid_out`/`data_out` are held stable under stall, and no beat is lost or duplicated.
6. **Reset mid-frame.** Assert `rst` for 1 cycle after the first beat of an R=1 frame → next edge `valid_out`=0, `keep_out`=0. The following frame (R=0, 0xCAFEF00D, last) outputs 0xCAFEF00D keep 1111 last.

Source files
------------

// File: rtl/axi_stream_remove_header.sv
// axi_stream_remove_header: strips a per-frame count of leading bytes from
// an AXI-Stream frame and re-packs the remaining bytes MSB-first so that
// every non-final output beat is full. The output stage is registered and
// sustains one beat per cycle.
module axi_stream_remove_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    input  logic [BYTE_CNT_WD:0]    byte_remove_cnt,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out
);
    // Byte counts reach residue (<= N-1) plus one beat (<= N), so two
    // extra bits over the byte index cover every intermediate total.
    localparam int                CNT_WD = BYTE_CNT_WD + 2;
    localparam logic [CNT_WD-1:0] FULL   = CNT_WD'(DATA_BYTE_WD);

    typedef enum logic [1:0] {S_FIRST, S_STREAM, S_FLUSH} state_t;

    state_t                  state, state_nxt;
    logic [DATA_WD-1:0]      res_data, res_data_nxt;   // MSB-aligned, zero padded
    logic [CNT_WD-1:0]       res_cnt, res_cnt_nxt;

    logic                    out_free, accept;
    logic [DATA_WD-1:0]      beat_mask, beat_sh;
    logic [CNT_WD-1:0]       n_in, r_clamp, drop, total, remain;
    logic [2*DATA_WD-1:0]    merged;

    logic                    load, load_last;
    logic [DATA_WD-1:0]      load_data;
    logic [DATA_BYTE_WD-1:0] load_keep;

    // Leading-ones keep mask for a beat carrying cnt bytes.
    function automatic logic [DATA_BYTE_WD-1:0] lead_ones(input logic [CNT_WD-1:0] cnt);
        logic [DATA_BYTE_WD-1:0] m;
        m = '0;
        for (int j = 0; j < DATA_BYTE_WD; j++)
            if (CNT_WD'(DATA_BYTE_WD - 1 - j) < cnt) m[j] = 1'b1;
        return m;
    endfunction

    // Output register is free when empty or being drained this cycle.
    assign out_free = !valid_out || ready_out;
    assign ready_in = !rst && (state != S_FLUSH) && out_free;
    assign accept   = valid_in && ready_in;

    // Mask invalid bytes, strip the head bytes and append the beat behind the residue.
    always_comb begin
        beat_mask = '0;
        n_in      = '0;
        for (int j = 0; j < DATA_BYTE_WD; j++) begin
            if (keep_in[j]) begin
                beat_mask[j*8 +: 8] = data_in[j*8 +: 8];
                n_in = n_in + CNT_WD'(1);
            end
        end
        r_clamp = (CNT_WD'(byte_remove_cnt) > FULL) ? FULL : CNT_WD'(byte_remove_cnt);
        drop    = '0;
        if (state == S_FIRST)
            drop = (r_clamp < n_in) ? r_clamp : n_in;
        beat_sh = beat_mask << {drop, 3'b000};
        total   = res_cnt + n_in - drop;
        remain  = total - FULL;
        merged  = {res_data, {DATA_WD{1'b0}}}
                | ({beat_sh, {DATA_WD{1'b0}}} >> {res_cnt, 3'b000});
    end

    // Next state, residue update and the beat to load into the output register.
    always_comb begin
        state_nxt    = state;
        res_data_nxt = res_data;
        res_cnt_nxt  = res_cnt;
        load         = 1'b0;
        load_data    = merged[2*DATA_WD-1 -: DATA_WD];
        load_keep    = '1;
        load_last    = 1'b0;
        case (state)
            S_FLUSH: begin
                if (out_free) begin
                    load         = 1'b1;
                    load_data    = res_data;
                    load_keep    = lead_ones(res_cnt);
                    load_last    = 1'b1;
                    res_data_nxt = '0;
                    res_cnt_nxt  = '0;
                    state_nxt    = S_FIRST;
                end
            end
            default: begin
                if (accept) begin
                    state_nxt = last_in ? S_FIRST : S_STREAM;
                    if (total >= FULL) begin
                        // A full beat is ready; the remainder stays behind.
                        load         = 1'b1;
                        res_data_nxt = merged[DATA_WD-1:0];
                        res_cnt_nxt  = remain;
                        if (last_in) begin
                            if (remain != '0) state_nxt = S_FLUSH;
                            else              load_last = 1'b1;
                        end
                    end else if (last_in) begin
                        // Short tail: emit as partial beat, or drop an empty frame.
                        load         = (total != '0);
                        load_keep    = lead_ones(total);
                        load_last    = 1'b1;
                        res_data_nxt = '0;
                        res_cnt_nxt  = '0;
                    end else begin
                        res_data_nxt = merged[2*DATA_WD-1 -: DATA_WD];
                        res_cnt_nxt  = total;
                    end
                end
            end
        endcase
    end

    // FSM state and residue registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FIRST;
            res_data <= '0;
            res_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            res_data <= res_data_nxt;
            res_cnt  <= res_cnt_nxt;
        end
    end

    // Output register: reloads whenever freed, holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            keep_out  <= '0;
            last_out  <= 1'b0;
        end else if (out_free) begin
            valid_out <= load;
            if (load) begin
                data_out <= load_data;
                keep_out <= load_keep;
                last_out <= load_last;
            end
        end
    end
endmodule
